// File: rtl/mem_bus_pkg.sv
// Shared types and default region map for the memory-bus controller.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_UNMAPPED = 2'b01,
    FC_RO_WRITE = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_e;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_N_REG  = 6;

  localparam logic [DEF_ADDR_W-1:0] FLASH_BASE = 11'h400;
  localparam logic [DEF_ADDR_W-1:0] SRAM_BASE  = 11'h410;
  localparam logic [DEF_ADDR_W-1:0] UART_BASE  = 11'h450;
  localparam logic [DEF_ADDR_W-1:0] TIM1_BASE  = 11'h459;
  localparam logic [DEF_ADDR_W-1:0] TIM6_BASE  = 11'h469;
  localparam logic [DEF_ADDR_W-1:0] GPIO_BASE  = 11'h470;
  localparam logic [DEF_ADDR_W-1:0] MAP_END    = 11'h480;

  // Region i lives in bits [i*ADDR_W +: ADDR_W]; limits are exclusive.
  localparam logic [DEF_N_REG*DEF_ADDR_W-1:0] DEF_REG_BASE =
    {GPIO_BASE, TIM6_BASE, TIM1_BASE, UART_BASE, SRAM_BASE, FLASH_BASE};
  localparam logic [DEF_N_REG*DEF_ADDR_W-1:0] DEF_REG_LIMIT =
    {MAP_END, GPIO_BASE, TIM6_BASE, TIM1_BASE, UART_BASE, SRAM_BASE};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Core-side request/response handshake of the memory-bus controller.
interface mem_bus_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_done;
  logic              m_err;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_done, m_err, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_done, m_err, m_rdata
  );
endinterface

// File: rtl/mem_region_decode.sv
// Combinational priority decoder: address -> region hit, one-hot select,
// region-relative offset and read-only flag. Lowest index wins on overlap.
module mem_region_decode #(
  parameter int                        ADDR_W    = 11,
  parameter int                        N_REG     = 6,
  parameter logic [N_REG*ADDR_W-1:0]   REG_BASE  = '0,
  parameter logic [N_REG*ADDR_W-1:0]   REG_LIMIT = '0,
  parameter logic [N_REG-1:0]          REG_RO    = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [N_REG-1:0]  sel_o,
  output logic [ADDR_W-1:0] offset_o,
  output logic              ro_o
);

  always_comb begin
    hit_o    = 1'b0;
    sel_o    = '0;
    offset_o = '0;
    ro_o     = 1'b0;
    // Walk from the top so the lowest matching index overwrites last.
    for (int i = N_REG - 1; i >= 0; i--) begin
      if ((addr_i >= REG_BASE[i*ADDR_W +: ADDR_W]) &&
          (addr_i <  REG_LIMIT[i*ADDR_W +: ADDR_W])) begin
        hit_o    = 1'b1;
        sel_o    = '0;
        sel_o[i] = 1'b1;
        offset_o = addr_i - REG_BASE[i*ADDR_W +: ADDR_W];
        ro_o     = REG_RO[i];
      end
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: decode, single-cycle slave enable, bounded ack wait,
// read data return and sticky fault recording.
//   state  | meaning
//   IDLE   | ready for a request; decode and accept or fault
//   ACCESS | s_en pulse to selected slave; zero-wait ack sampled
//   WAIT   | waiting for ack, timer running toward TIMEOUT
//   RESP   | good completion pulse (m_done, m_err=0)
//   ERR    | faulted completion pulse (m_done, m_err=1)
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                      ADDR_W    = 11,
  parameter int                      DATA_W    = 32,
  parameter int                      N_REG     = 6,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE  = DEF_REG_BASE,
  parameter logic [N_REG*ADDR_W-1:0] REG_LIMIT = DEF_REG_LIMIT,
  parameter logic [N_REG-1:0]        REG_RO    = '0,
  parameter int                      TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_bus_if.slave                  mbus,
  output logic [N_REG-1:0]          s_en,
  output logic                      s_we,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [N_REG-1:0]          s_ack,
  input  logic [N_REG*DATA_W-1:0]   s_rdata,
  output logic [1:0]                fault_cause,
  output logic [ADDR_W-1:0]         fault_addr,
  output logic [7:0]                fault_cnt,
  input  logic                      fault_clr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q;
  logic                ready_q, done_q, err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [N_REG-1:0]    sel_q, s_en_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q, s_addr_q;
  logic [DATA_W-1:0]   s_wdata_q;
  logic [TW-1:0]       timer_q;
  fault_e              fault_cause_q;
  logic [ADDR_W-1:0]   fault_addr_q;
  logic [7:0]          fault_cnt_q;

  logic                dec_hit, dec_ro;
  logic [N_REG-1:0]    dec_sel;
  logic [ADDR_W-1:0]   dec_off;
  logic                ack_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [7:0]          fault_cnt_d;

  mem_region_decode #(
    .ADDR_W   (ADDR_W),
    .N_REG    (N_REG),
    .REG_BASE (REG_BASE),
    .REG_LIMIT(REG_LIMIT),
    .REG_RO   (REG_RO)
  ) u_decode (
    .addr_i  (mbus.m_addr),
    .hit_o   (dec_hit),
    .sel_o   (dec_sel),
    .offset_o(dec_off),
    .ro_o    (dec_ro)
  );

  always_comb begin
    ack_d   = |(s_ack & sel_q);
    rdata_d = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (sel_q[i]) rdata_d = s_rdata[i*DATA_W +: DATA_W];
    end
    // A clear in the same cycle as a new fault restarts the count at one.
    fault_cnt_d = fault_clr ? 8'd1 : sat_inc8(fault_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      sel_q         <= '0;
      s_en_q        <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      timer_q       <= '0;
      fault_cause_q <= FC_NONE;
      fault_addr_q  <= '0;
      fault_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      s_en_q <= '0;
      // The fault just recorded on entry to ERR must survive a clear.
      if (fault_clr && state_q != ST_ERR) begin
        fault_cause_q <= FC_NONE;
        fault_addr_q  <= '0;
        fault_cnt_q   <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (mbus.m_req) begin
            ready_q <= 1'b0;
            addr_q  <= mbus.m_addr;
            if (!dec_hit || (dec_ro && mbus.m_we)) begin
              state_q       <= ST_ERR;
              done_q        <= 1'b1;
              err_q         <= 1'b1;
              fault_cause_q <= !dec_hit ? FC_UNMAPPED : FC_RO_WRITE;
              fault_addr_q  <= mbus.m_addr;
              fault_cnt_q   <= fault_cnt_d;
            end else begin
              state_q   <= ST_ACCESS;
              sel_q     <= dec_sel;
              s_en_q    <= dec_sel;
              we_q      <= mbus.m_we;
              s_addr_q  <= dec_off;
              s_wdata_q <= mbus.m_wdata;
            end
          end
        end
        ST_ACCESS, ST_WAIT: begin
          if (ack_d) begin
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            if (!we_q) rdata_q <= rdata_d;
          end else if (state_q == ST_ACCESS) begin
            state_q <= ST_WAIT;
            timer_q <= '0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q       <= ST_ERR;
            done_q        <= 1'b1;
            err_q         <= 1'b1;
            fault_cause_q <= FC_TIMEOUT;
            fault_addr_q  <= addr_q;
            fault_cnt_q   <= fault_cnt_d;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESP, ST_ERR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign mbus.m_ready = ready_q;
  assign mbus.m_done  = done_q;
  assign mbus.m_err   = err_q;
  assign mbus.m_rdata = rdata_q;
  assign s_en         = s_en_q;
  assign s_we         = we_q;
  assign s_addr       = s_addr_q;
  assign s_wdata      = s_wdata_q;
  assign fault_cause  = fault_cause_q;
  assign fault_addr   = fault_addr_q;
  assign fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with hand-computed expectations on the
// default region map (flash marked read-only).
module tb_mem_bus_ctrl;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 32;
  localparam int N_REG   = 6;
  localparam int TIMEOUT = 15;

  localparam logic [5:0] SEL_FLASH = 6'b000001;
  localparam logic [5:0] SEL_SRAM  = 6'b000010;
  localparam logic [5:0] SEL_UART  = 6'b000100;
  localparam logic [5:0] SEL_TIM1  = 6'b001000;
  localparam logic [5:0] SEL_GPIO  = 6'b100000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REG-1:0]        s_en;
  logic                    s_we;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_REG-1:0]        s_ack;
  logic [N_REG*DATA_W-1:0] s_rdata;
  logic [1:0]              fault_cause;
  logic [ADDR_W-1:0]       fault_addr;
  logic [7:0]              fault_cnt;
  logic                    fault_clr;

  int n_chk  = 0;
  int n_pass = 0;

  mem_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mbus ();

  mem_bus_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_REG  (N_REG),
    .REG_RO (6'b000001),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mbus       (mbus),
    .s_en       (s_en),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_ack      (s_ack),
    .s_rdata    (s_rdata),
    .fault_cause(fault_cause),
    .fault_addr (fault_addr),
    .fault_cnt  (fault_cnt),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    mbus.m_req   = 1'b1;
    mbus.m_we    = we;
    mbus.m_addr  = addr;
    mbus.m_wdata = wd;
    tick();
    mbus.m_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst          = 1'b0;
    mbus.m_req   = 1'b0;
    mbus.m_we    = 1'b0;
    mbus.m_addr  = '0;
    mbus.m_wdata = '0;
    s_ack        = '0;
    s_rdata      = '0;
    fault_clr    = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(mbus.m_ready), 32'd1);
    check("rst_done",  32'(mbus.m_done),  32'd0);
    check("rst_rdata", mbus.m_rdata,      32'd0);
    check("rst_s_en",  32'(s_en),         32'd0);
    check("rst_fcnt",  32'(fault_cnt),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait SRAM read.
    check("idle_ready", 32'(mbus.m_ready), 32'd1);
    issue(1'b0, 11'h412, '0);
    check("sram_s_en",   32'(s_en),   32'(SEL_SRAM));
    check("sram_s_addr", 32'(s_addr), 32'h002);
    check("sram_s_we",   32'(s_we),   32'd0);
    check("sram_ready",  32'(mbus.m_ready), 32'd0);
    check("sram_nodone", 32'(mbus.m_done),  32'd0);
    s_ack = SEL_SRAM;
    s_rdata[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    tick();
    s_ack = '0;
    check("sram_done",  32'(mbus.m_done), 32'd1);
    check("sram_err",   32'(mbus.m_err),  32'd0);
    check("sram_rdata", mbus.m_rdata,     32'hDEADBEEF);
    check("sram_s_en0", 32'(s_en),        32'd0);
    tick();
    check("sram_done0",  32'(mbus.m_done),  32'd0);
    check("sram_ready1", 32'(mbus.m_ready), 32'd1);

    // Zero-wait flash read at the last flash address.
    issue(1'b0, 11'h40F, '0);
    check("flash_s_en",   32'(s_en),   32'(SEL_FLASH));
    check("flash_s_addr", 32'(s_addr), 32'h00F);
    s_ack = SEL_FLASH;
    s_rdata[0 +: DATA_W] = 32'h11223344;
    tick();
    s_ack = '0;
    check("flash_rdata", mbus.m_rdata, 32'h11223344);
    tick();

    // Write to read-only flash.
    issue(1'b1, 11'h405, 32'h1234);
    check("ro_s_en",   32'(s_en),         32'd0);
    check("ro_done",   32'(mbus.m_done),  32'd1);
    check("ro_err",    32'(mbus.m_err),   32'd1);
    check("ro_cause",  32'(fault_cause),  32'd2);
    check("ro_addr",   32'(fault_addr),   32'h405);
    check("ro_cnt",    32'(fault_cnt),    32'd1);
    check("ro_rdata",  mbus.m_rdata,      32'h11223344);
    tick();

    // Exclusive limit: first address past GPIO is unmapped.
    issue(1'b0, 11'h480, '0);
    check("lim_err",   32'(mbus.m_err),  32'd1);
    check("lim_cause", 32'(fault_cause), 32'd1);
    check("lim_cnt",   32'(fault_cnt),   32'd2);
    tick();

    // Unmapped read, repeated to saturation.
    issue(1'b0, 11'h7F0, '0);
    check("unm_cause", 32'(fault_cause), 32'd1);
    check("unm_addr",  32'(fault_addr),  32'h7F0);
    check("unm_cnt",   32'(fault_cnt),   32'd3);
    tick();
    for (int i = 0; i < 299; i++) begin
      issue(1'b0, 11'h7F0, '0);
      tick();
    end
    check("sat_cnt", 32'(fault_cnt), 32'd255);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_cause", 32'(fault_cause), 32'd0);
    check("clr_addr",  32'(fault_addr),  32'd0);
    check("clr_cnt",   32'(fault_cnt),   32'd0);

    // Fault and clear together: the new fault wins.
    fault_clr = 1'b1;
    issue(1'b0, 11'h000, '0);
    check("clrhit_cause", 32'(fault_cause), 32'd1);
    check("clrhit_addr",  32'(fault_addr),  32'h000);
    check("clrhit_cnt",   32'(fault_cnt),   32'd1);
    tick();
    fault_clr = 1'b0;
    check("clrhit_keep", 32'(fault_cnt), 32'd1);

    // GPIO read, slave silent -> timeout.
    issue(1'b0, 11'h475, '0);
    check("gpio_s_en",   32'(s_en),   32'(SEL_GPIO));
    check("gpio_s_addr", 32'(s_addr), 32'h005);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mbus.m_done && n < 40);
    check("tmo_edges", 32'(n), 32'(TIMEOUT + 1));
    check("tmo_err",   32'(mbus.m_err),  32'd1);
    check("tmo_cause", 32'(fault_cause), 32'd3);
    check("tmo_addr",  32'(fault_addr),  32'h475);
    check("tmo_cnt",   32'(fault_cnt),   32'd2);
    tick();
    tick();
    tick();
    s_ack = SEL_GPIO;
    s_rdata[5*DATA_W +: DATA_W] = 32'h55555555;
    tick();
    s_ack = '0;
    check("late_done",  32'(mbus.m_done), 32'd0);
    check("late_rdata", mbus.m_rdata,     32'h11223344);
    check("late_ready", 32'(mbus.m_ready), 32'd1);

    // UART write, ack after 4 WAIT cycles, timer ack meanwhile.
    issue(1'b1, 11'h452, 32'hCAFEF00D);
    check("uart_s_en",   32'(s_en),    32'(SEL_UART));
    check("uart_s_we",   32'(s_we),    32'd1);
    check("uart_s_addr", 32'(s_addr),  32'h002);
    check("uart_wdata",  s_wdata,      32'hCAFEF00D);
    s_ack = SEL_TIM1;
    s_rdata[3*DATA_W +: DATA_W] = 32'h77777777;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("uart_wait", 32'(mbus.m_done), 32'd0);
    end
    s_ack = SEL_UART;
    tick();
    s_ack = '0;
    check("uart_done",  32'(mbus.m_done), 32'd1);
    check("uart_err",   32'(mbus.m_err),  32'd0);
    check("uart_rdata", mbus.m_rdata,     32'h11223344);
    tick();

    // Reset during WAIT.
    issue(1'b0, 11'h420, '0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready",   32'(mbus.m_ready), 32'd1);
    check("arst_done",    32'(mbus.m_done),  32'd0);
    check("arst_rdata",   mbus.m_rdata,      32'd0);
    check("arst_s_we",    32'(s_we),         32'd0);
    check("arst_s_addr",  32'(s_addr),       32'd0);
    check("arst_s_wdata", s_wdata,           32'd0);
    check("arst_cause",   32'(fault_cause),  32'd0);
    check("arst_cnt",     32'(fault_cnt),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    s_ack = SEL_SRAM;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mbus.m_done) n++;
    end
    s_ack = '0;
    check("arst_nodone", 32'(n), 32'd0);
    issue(1'b0, 11'h411, '0);
    check("post_s_addr", 32'(s_addr), 32'h001);
    s_ack = SEL_SRAM;
    s_rdata[1*DATA_W +: DATA_W] = 32'h0BADF00D;
    tick();
    s_ack = '0;
    check("post_done",  32'(mbus.m_done), 32'd1);
    check("post_rdata", mbus.m_rdata,     32'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
